// File: rtl/seq_det_pkg.sv
// Shared constants, types and helpers for the programmable serial pattern detector.
// Imported by the interface, the match counter and the detector top.
package seq_det_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

  // Out of reset every pattern bit is this value and the length is the full PAT_W.
  localparam bit RST_PAT_BIT = 1'b0;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int rst_len(input int pat_w);
    return pat_w;
  endfunction

  // What a cycle does to the detector history.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2
  } op_e;

endpackage

// File: rtl/seq_det_prog_if.sv
// Config, stream and status signals of the detector, bundled for the module port.
// The DUT uses the slave modport and the driving environment uses the master modport.
interface seq_det_prog_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEN_W = len_w(PAT_W)
) ();

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cfg_err;
  logic             in_valid;
  logic             seq_in;
  logic             clr_count;
  logic             detected;
  logic [CNT_W-1:0] match_count;
  logic [LEN_W-1:0] state_out;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    output in_valid, seq_in, clr_count,
    input  cfg_err, detected, match_count, state_out
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap,
    input  in_valid, seq_in, clr_count,
    output cfg_err, detected, match_count, state_out
  );

endinterface

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter with synchronous clear; clear beats increment.
// Shared by the detector family, so it knows nothing about patterns.
module seq_det_match_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector: masked compare of the newest len_q
// stream bits against pat_q, with overlapping or non-overlapping restart.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst_n,
  seq_det_prog_if.slave bus
);

  localparam int               LEN_W   = len_w(PAT_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             det_q, det_d;
  logic             err_q, err_d;

  logic             cfg_legal;
  op_e              op;
  logic [PAT_W-1:0] nh;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] nf;
  logic             hit;
  logic             inc;

  // A legal config write owns the cycle; an illegal one lets the stream bit through.
  always_comb begin : decode
    cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
    if (bus.cfg_we && cfg_legal) begin
      op = OP_LOAD;
    end else if (bus.in_valid) begin
      op = OP_SHIFT;
    end else begin
      op = OP_HOLD;
    end
  end

  always_comb begin : match
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mask = '0;
    nh   = {hist_q[PAT_W-2:0], bus.seq_in};
    nf   = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    // Only compare bits received since the last restart, and only the low len_q of them.
    hit = (nf >= len_q) && (((nh ^ pat_q) & mask) == '0);
  end

  always_comb begin : next_state
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    det_d  = 1'b0;
    inc    = 1'b0;
    err_d  = bus.cfg_we && !cfg_legal;
    unique case (op)
      OP_LOAD: begin
        pat_d  = bus.cfg_pattern;
        len_d  = bus.cfg_len;
        ovl_d  = bus.cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end
      OP_SHIFT: begin
        hist_d = nh;
        det_d  = hit;
        inc    = hit;
        fill_d = (hit && !ovl_q) ? '0 : nf;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values; '=' here races.
  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= {PAT_W{RST_PAT_BIT}};
      len_q  <= LEN_W'(rst_len(PAT_W));
      ovl_q  <= 1'b0;
      det_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      det_q  <= det_d;
      err_q  <= err_d;
    end
  end

  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .clr   (bus.clr_count),
    .count (bus.match_count)
  );

  assign bus.detected  = det_q;
  assign bus.cfg_err   = err_q;
  assign bus.state_out = fill_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios plus random traffic checked against a
// queue-based reference model; two DUTs share stimulus (8-bit and 2-bit counters).
module tb_seq_det_prog;
  import seq_det_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_A = 8;
  localparam int CNT_B = 2;
  localparam int LEN_W = len_w(PAT_W);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             in_valid;
  logic             seq_in;
  logic             clr_count;

  seq_det_prog_if #(.PAT_W(PAT_W), .CNT_W(CNT_A)) bus_a ();
  seq_det_prog_if #(.PAT_W(PAT_W), .CNT_W(CNT_B)) bus_b ();

  assign bus_a.cfg_we      = cfg_we;
  assign bus_a.cfg_pattern = cfg_pattern;
  assign bus_a.cfg_len     = cfg_len;
  assign bus_a.cfg_overlap = cfg_overlap;
  assign bus_a.in_valid    = in_valid;
  assign bus_a.seq_in      = seq_in;
  assign bus_a.clr_count   = clr_count;
  assign bus_b.cfg_we      = cfg_we;
  assign bus_b.cfg_pattern = cfg_pattern;
  assign bus_b.cfg_len     = cfg_len;
  assign bus_b.cfg_overlap = cfg_overlap;
  assign bus_b.in_valid    = in_valid;
  assign bus_b.seq_in      = seq_in;
  assign bus_b.clr_count   = clr_count;

  seq_det_prog #(.PAT_W(PAT_W), .CNT_W(CNT_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  seq_det_prog #(.PAT_W(PAT_W), .CNT_W(CNT_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int pulses;

  // Reference model: the accepted bits since the last restart, newest at the back.
  bit               q[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               e_det, e_err;
  int               e_cnt_a, e_cnt_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit hit;
    hit = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_pat   = '0;
      m_len   = PAT_W;
      m_ovl   = 1'b0;
      e_err   = 1'b0;
      e_cnt_a = 0;
      e_cnt_b = 0;
    end else begin
      e_err = cfg_we && !(cfg_len >= 1 && cfg_len <= PAT_W);
      if (cfg_we && !e_err) begin
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ovl = cfg_overlap;
        q.delete();
      end else if (in_valid) begin
        q.push_back(seq_in);
        if (q.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
        if (hit && !m_ovl) q.delete();
        if (q.size() > 64) void'(q.pop_front());
      end
      if (clr_count) begin
        e_cnt_a = 0;
        e_cnt_b = 0;
      end else if (hit) begin
        if (e_cnt_a < (1 << CNT_A) - 1) e_cnt_a++;
        if (e_cnt_b < (1 << CNT_B) - 1) e_cnt_b++;
      end
    end
    e_det = hit;
  endfunction

  task automatic tick();
    int e_fill;
    model_step();
    @(posedge clk);
    #1;
    e_fill = (q.size() > PAT_W) ? PAT_W : q.size();
    check("detected_a", bus_a.detected, e_det);
    check("detected_b", bus_b.detected, e_det);
    check("cfg_err", bus_a.cfg_err, e_err);
    check("count_a", bus_a.match_count, e_cnt_a);
    check("count_b", bus_b.match_count, e_cnt_b);
    check("state_out", bus_a.state_out, e_fill);
    if (bus_a.detected === 1'b1) pulses++;
  endtask

  task automatic quiet();
    cfg_we    = 1'b0;
    in_valid  = 1'b0;
    clr_count = 1'b0;
    seq_in    = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    pulses = 0;
  endtask

  task automatic bit_in(input bit b);
    in_valid = 1'b1;
    seq_in   = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input int len, input bit ovl);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    bit stream3[12];
    stream3 = '{0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1};
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    quiet();
    do_reset();
    check("reset_fill", bus_a.state_out, 0);

    // 101 non-overlapping; bit 3 of the pattern is outside len and must be ignored.
    load(4'b1101, 3, 1'b0);
    bit_in(1); bit_in(0); bit_in(1);
    check("t1_pulse_bit3", bus_a.detected, 1);
    bit_in(0); bit_in(1);
    check("t1_pulses", pulses, 1);
    check("t1_count", bus_a.match_count, 1);
    check("t1_fill", bus_a.state_out, 2);

    do_reset();
    load(4'b0101, 3, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    check("t2_pulse_bit5", bus_a.detected, 1);
    check("t2_pulses", pulses, 2);
    check("t2_count", bus_a.match_count, 2);

    // 1100 with idle gaps between accepted bits.
    do_reset();
    load(4'b1100, 4, 1'b0);
    for (int i = 0; i < 12; i++) begin
      bit_in(stream3[i]);
      if (i == 5) check("t3_pulse_bit6", bus_a.detected, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    check("t3_pulses", pulses, 1);

    // Illegal length: error pulse, old pattern keeps matching with the same-cycle bit.
    do_reset();
    load(4'b0101, 3, 1'b0);
    bit_in(1); bit_in(0);
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_len = '0; in_valid = 1'b1; seq_in = 1'b1;
    tick();
    quiet();
    check("t4_err_pulse", bus_a.cfg_err, 1);
    check("t4_old_hit", bus_a.detected, 1);
    tick();
    check("t4_err_clears", bus_a.cfg_err, 0);
    // Legal write mid-match drops the partial match and the same-cycle bit.
    bit_in(1); bit_in(0);
    cfg_we = 1'b1; cfg_pattern = 4'b0101; cfg_len = 3'd3; cfg_overlap = 1'b0;
    in_valid = 1'b1; seq_in = 1'b1;
    tick();
    quiet();
    check("t4_load_no_hit", bus_a.detected, 0);
    check("t4_load_fill", bus_a.state_out, 0);
    bit_in(1);
    check("t4_restart_fill", bus_a.state_out, 1);
    bit_in(0); bit_in(1);
    check("t4_new_hit", bus_a.detected, 1);

    // len 1 overlapping: pulse every cycle; 2-bit counter saturates.
    do_reset();
    load(4'b0001, 1, 1'b1);
    for (int i = 0; i < 6; i++) bit_in(1);
    check("t5_pulses", pulses, 6);
    check("t5_count_a", bus_a.match_count, 6);
    check("t5_count_b_sat", bus_b.match_count, 3);
    clr_count = 1'b1;
    bit_in(1);
    clr_count = 1'b0;
    check("t5_clr_hit_det", bus_a.detected, 1);
    check("t5_clr_count_a", bus_a.match_count, 0);
    check("t5_clr_count_b", bus_b.match_count, 0);

    // Reset mid-pattern beats a simultaneous config write and bit.
    do_reset();
    load(4'b0101, 3, 1'b0);
    bit_in(1); bit_in(0);
    rst_n = 1'b0; cfg_we = 1'b1; cfg_pattern = 4'b0001; cfg_len = 3'd1; cfg_overlap = 1'b1;
    in_valid = 1'b1; seq_in = 1'b1; clr_count = 1'b1;
    tick();
    quiet();
    rst_n = 1'b1;
    check("t6_rst_det", bus_a.detected, 0);
    check("t6_rst_err", bus_a.cfg_err, 0);
    check("t6_rst_count", bus_a.match_count, 0);
    check("t6_rst_fill", bus_a.state_out, 0);
    bit_in(1);
    check("t6_no_pulse", bus_a.detected, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      cfg_we      = ($urandom_range(0, 29) == 0);
      cfg_pattern = PAT_W'($urandom);
      cfg_len     = LEN_W'($urandom_range(0, 7));
      cfg_overlap = 1'($urandom);
      in_valid    = ($urandom_range(0, 3) != 0);
      seq_in      = 1'($urandom);
      clr_count   = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
